// File: rtl/regfile_writeback_queue_if.sv
// Producer requests, register-file write port and forwarding taps of the write-back queue.
// master = producer/register-file side, slave = the queue itself.
interface regfile_writeback_queue_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 4
);
  logic                    mem_valid;
  logic [ADDR_WIDTH-1:0]   mem_dest;
  logic [DATA_WIDTH-1:0]   mem_result;
  logic                    alu_valid;
  logic [ADDR_WIDTH-1:0]   alu_dest;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic                    stall;

  logic [ADDR_WIDTH-1:0]   RW;
  logic [DATA_WIDTH-1:0]   BusW;
  logic                    sig_enable_write;

  logic [ADDR_WIDTH-1:0]   RA;
  logic [ADDR_WIDTH-1:0]   RB;
  logic                    fwdA_hit;
  logic                    fwdB_hit;
  logic [DATA_WIDTH-1:0]   fwdA_data;
  logic [DATA_WIDTH-1:0]   fwdB_data;

  logic [$clog2(DEPTH):0]  count;

  modport master (
    output mem_valid, mem_dest, mem_result,
    output alu_valid, alu_dest, alu_result,
    output RA, RB,
    input  stall, RW, BusW, sig_enable_write,
    input  fwdA_hit, fwdB_hit, fwdA_data, fwdB_data, count
  );

  modport slave (
    input  mem_valid, mem_dest, mem_result,
    input  alu_valid, alu_dest, alu_result,
    input  RA, RB,
    output stall, RW, BusW, sig_enable_write,
    output fwdA_hit, fwdB_hit, fwdA_data, fwdB_data, count
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order write-back buffer driving the single register-file write port, with forwarding of pending writes.
// Empty-queue latency: accepted at edge E, on RW/BusW after E+1; stall refuses all of a cycle's requests when space is short.
module regfile_writeback_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  regfile_writeback_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t          entries [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   alu_slot;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   free_slots;
  logic [CW-1:0]   push_n;
  logic [1:0]      need;
  logic            accept;
  logic            pop;
  entry_t          mem_entry;
  entry_t          alu_entry;
  entry_t          port_q;
  logic            port_vld;
  logic [DATA_WIDTH:0] fwd_a;
  logic [DATA_WIDTH:0] fwd_b;

  // Admission: all-or-nothing, and a same-cycle pop earns no credit.
  always_comb begin
    need       = {1'b0, bus.mem_valid} + {1'b0, bus.alu_valid};
    free_slots = DEPTH_C - count_q;
    bus.stall  = CW'(need) > free_slots;
    accept     = !bus.stall;
    push_n     = accept ? CW'(need) : '0;
    pop        = count_q != '0;
    alu_slot   = tail + PW'(bus.mem_valid);
    mem_entry  = '{dest: bus.mem_dest, data: bus.mem_result};
    alu_entry  = '{dest: bus.alu_dest, data: bus.alu_result};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
      port_q   <= '0;
      port_vld <= 1'b0;
    end else begin
      if (accept) begin
        tail <= tail + PW'(need);
      end
      if (pop) begin
        head   <= head + PW'(1);
        port_q <= entries[head];
      end
      port_vld <= pop;
      count_q  <= count_q + push_n - CW'(pop);
    end
  end

  // Storage needs no reset: occupancy is tracked solely by count_q.
  always_ff @(posedge clock) begin
    if (accept) begin
      if (bus.mem_valid) begin
        entries[tail] <= mem_entry;
      end
      if (bus.alu_valid) begin
        entries[alu_slot] <= alu_entry;
      end
    end
  end

  // Scan oldest to newest so the youngest matching write overrides older ones.
  function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDR_WIDTH-1:0] addr);
    logic                  hit;
    logic [DATA_WIDTH-1:0] data;
    logic [PW-1:0]         idx;
    hit  = port_vld && (port_q.dest == addr);
    data = hit ? port_q.data : '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count_q) && (entries[idx].dest == addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
    return {hit, data};
  endfunction

  always_comb begin
    fwd_a         = lookup(bus.RA);
    fwd_b         = lookup(bus.RB);
    bus.fwdA_hit  = fwd_a[DATA_WIDTH];
    bus.fwdA_data = fwd_a[DATA_WIDTH-1:0];
    bus.fwdB_hit  = fwd_b[DATA_WIDTH];
    bus.fwdB_data = fwd_b[DATA_WIDTH-1:0];
  end

  assign bus.RW               = port_q.dest;
  assign bus.BusW             = port_q.data;
  assign bus.sig_enable_write = port_vld;
  assign bus.count            = count_q;

endmodule
